// File: rtl/sd_rd_arbiter.sv
// sd_rd_arbiter: round-robin scheduler sharing one SD sector-read engine between two burst requesters; define SD_ARB_TIMEOUT_EN to add a per-sector watchdog
module sd_rd_arbiter #(
  parameter int          SEC_CNT_W   = 16,
  parameter logic [31:0] TIMEOUT_CYC = 32'd50_000_000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0,
  input  logic                 req1,
  input  logic [31:0]          addr0,
  input  logic [31:0]          addr1,
  input  logic [SEC_CNT_W-1:0] num0,
  input  logic [SEC_CNT_W-1:0] num1,
  output logic                 ack0,
  output logic                 ack1,
  output logic                 done0,
  output logic                 done1,
  output logic                 err,
  output logic                 owner,
  output logic                 arb_busy,
  input  logic                 rd_busy,
  output logic                 rd_start_en,
  output logic [31:0]          rd_sec_addr,
  input  logic                 sd_rd_val_en,
  input  logic [15:0]          sd_rd_val_data,
  output logic                 val_en0,
  output logic                 val_en1,
  output logic [15:0]          val_data
);
  typedef enum logic [2:0] {IDLE, GRANT, ISSUE, WAIT, FIN} state_t;
  state_t               state_q;
  logic                 d0_q, d1_q, neg, to_hit, gnt, in_burst;
  logic                 owner_q, ack0_q, ack1_q, done0_q, done1_q, err_q, busy_q, start_q, ve0_q, ve1_q;
  logic [31:0]          base_q, addr_q;
  logic [15:0]          data_q;
  logic [SEC_CNT_W-1:0] num_q, cnt_q;
  assign neg         = d1_q & ~d0_q;
  assign gnt         = (req0 & req1) ? ~owner_q : req1;
  assign in_burst    = (state_q == ISSUE) || (state_q == WAIT);
  assign ack0        = ack0_q;
  assign ack1        = ack1_q;
  assign done0       = done0_q;
  assign done1       = done1_q;
  assign err         = err_q;
  assign owner       = owner_q;
  assign arb_busy    = busy_q;
  assign rd_start_en = start_q;
  assign rd_sec_addr = addr_q;
  assign val_en0     = ve0_q;
  assign val_en1     = ve1_q;
  assign val_data    = data_q;
`ifdef SD_ARB_TIMEOUT_EN
  logic [31:0] to_q;
  // cycles elapsed since the current sector was started
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) to_q <= '0;
    else        to_q <= (state_q == WAIT) ? to_q + 32'd1 : 32'd1;
  assign to_hit = to_q == TIMEOUT_CYC - 32'd1;
`else
  assign to_hit = 1'b0 & (TIMEOUT_CYC != 32'd0);
`endif
  // busy-fall sync, data routing and burst FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      {d0_q, d1_q} <= 2'b00;
      owner_q <= 1'b1;
      {ack0_q, ack1_q, done0_q, done1_q, err_q, busy_q, start_q, ve0_q, ve1_q} <= '0;
      base_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      num_q <= '0;
      cnt_q <= '0;
    end else begin
      d0_q <= rd_busy;
      d1_q <= d0_q;
      {ack0_q, ack1_q, done0_q, done1_q, err_q, start_q} <= '0;
      ve0_q <= sd_rd_val_en & in_burst & ~owner_q;
      ve1_q <= sd_rd_val_en & in_burst & owner_q;
      data_q <= sd_rd_val_data;
      case (state_q)
        IDLE: if (req0 | req1) begin
          owner_q <= gnt;
          base_q <= gnt ? addr1 : addr0;
          num_q <= gnt ? num1 : num0;
          ack0_q <= ~gnt;
          ack1_q <= gnt;
          busy_q <= 1'b1;
          cnt_q <= '0;
          state_q <= GRANT;
        end
        GRANT: if (num_q == '0) begin
          done0_q <= ~owner_q;
          done1_q <= owner_q;
          busy_q <= 1'b0;
          state_q <= FIN;
        end else begin
          start_q <= 1'b1;
          addr_q <= base_q;
          state_q <= ISSUE;
        end
        ISSUE: state_q <= WAIT;
        WAIT: if (neg) begin
          if (cnt_q == num_q - SEC_CNT_W'(1)) begin
            done0_q <= ~owner_q;
            done1_q <= owner_q;
            busy_q <= 1'b0;
            state_q <= FIN;
          end else begin
            cnt_q <= cnt_q + SEC_CNT_W'(1);
            addr_q <= base_q + 32'(cnt_q) + 32'd1;
            start_q <= 1'b1;
            state_q <= ISSUE;
          end
        end else if (to_hit) begin
          err_q <= 1'b1;
          busy_q <= 1'b0;
          state_q <= FIN;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sd_rd_arbiter.sv
// tb_sd_rd_arbiter: directed bench for sd_rd_arbiter with a simple engine model and event monitor
module tb_sd_rd_arbiter;
  logic        clk = 0, rst_n = 0;
  logic        req0 = 0, req1 = 0;
  logic [31:0] addr0 = 0, addr1 = 0;
  logic [15:0] num0 = 0, num1 = 0;
  logic        rd_busy = 0, sd_rd_val_en = 0;
  logic [15:0] sd_rd_val_data = 0;
  logic        ack0, ack1, done0, done1, err, owner, arb_busy, rd_start_en, val_en0, val_en1;
  logic [31:0] rd_sec_addr;
  logic [15:0] val_data;
  int checks = 0, errors = 0, cyc = 0, busy_len = 20, bcnt = 0, n_ve0 = 0, n_ve1 = 0;
  bit hold_busy = 0, busy_prev = 0;
  logic [31:0] st_addr[$];
  int st_cyc[$], g_own[$], g_cyc[$], d_own[$], d_cyc[$], e_cyc[$], f_cyc[$];

  sd_rd_arbiter #(.SEC_CNT_W(16), .TIMEOUT_CYC(32'd100)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .num0(num0), .num1(num1), .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1),
    .err(err), .owner(owner), .arb_busy(arb_busy), .rd_busy(rd_busy), .rd_start_en(rd_start_en),
    .rd_sec_addr(rd_sec_addr), .sd_rd_val_en(sd_rd_val_en), .sd_rd_val_data(sd_rd_val_data),
    .val_en0(val_en0), .val_en1(val_en1), .val_data(val_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // engine model: busy for busy_len cycles after each start, or forever while hold_busy
  always @(posedge clk)
    if (rd_start_en) begin
      rd_busy <= 1'b1;
      bcnt <= busy_len;
    end else if (rd_busy && !hold_busy) begin
      if (bcnt <= 1) rd_busy <= 1'b0;
      else bcnt <= bcnt - 1;
    end

  // event monitor sampling on the falling clock edge
  always @(negedge clk) begin
    if (rd_start_en) begin st_addr.push_back(rd_sec_addr); st_cyc.push_back(cyc); end
    if (ack0 || ack1) begin g_own.push_back(int'(ack1)); g_cyc.push_back(cyc); end
    if (done0 || done1) begin d_own.push_back(int'(done1)); d_cyc.push_back(cyc); end
    if (err) e_cyc.push_back(cyc);
    if (val_en0) n_ve0++;
    if (val_en1) n_ve1++;
    if (busy_prev && !rd_busy) f_cyc.push_back(cyc);
    busy_prev = rd_busy;
  end

  function automatic int at(input int q[$], input int i);
    return (i >= 0 && i < q.size()) ? q[i] : -999;
  endfunction
  function automatic logic [31:0] at_a(input int i);
    return (i >= 0 && i < st_addr.size()) ? st_addr[i] : 32'hDEAD_BEEF;
  endfunction
  function automatic logic [15:0] w(input int i);
    return 16'(i * 773 + 11);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #23;
    checks++; if ({ack0, ack1, done0, done1, err, arb_busy, rd_start_en, val_en0, val_en1} !== 9'b0) begin errors++; $display("FAIL reset_flags: got %b expected 0", {ack0, ack1, done0, done1, err, arb_busy, rd_start_en, val_en0, val_en1}); end
    checks++; if (rd_sec_addr !== 32'd0 || val_data !== 16'd0) begin errors++; $display("FAIL reset_buses: got addr %0h data %0h expected 0", rd_sec_addr, val_data); end
    checks++; if (owner !== 1'b1) begin errors++; $display("FAIL reset_owner: got %b expected 1", owner); end
  endtask

  task automatic test_round_robin();
    int gs, ds, got, dgot;
    gs = g_own.size(); ds = d_own.size(); busy_len = 3;
    step(); rst_n = 1;
    for (int i = 0; i < 600 && g_own.size() < gs + 4; i++) @(negedge clk);
    step(); req0 = 0; req1 = 0;
    for (int i = 0; i < 600 && d_own.size() < ds + 4; i++) @(negedge clk);
    got = at(g_own, gs) * 8 + at(g_own, gs + 1) * 4 + at(g_own, gs + 2) * 2 + at(g_own, gs + 3);
    dgot = at(d_own, ds) * 8 + at(d_own, ds + 1) * 4 + at(d_own, ds + 2) * 2 + at(d_own, ds + 3);
    checks++; if (got !== 5) begin errors++; $display("FAIL rr_grant_order: got %0d expected 5 (0,1,0,1)", got); end
    checks++; if (dgot !== 5) begin errors++; $display("FAIL rr_done_order: got %0d expected 5 (0,1,0,1)", dgot); end
    checks++; if (at(g_cyc, gs + 1) !== at(d_cyc, ds) + 2) begin errors++; $display("FAIL rr_regrant_cycle: got %0d expected %0d", at(g_cyc, gs + 1), at(d_cyc, ds) + 2); end
  endtask

  task automatic test_burst3();
    int s, gs, ds, fs;
    s = st_addr.size(); gs = g_own.size(); ds = d_own.size(); fs = f_cyc.size();
    busy_len = 20; addr0 = 32'd16448; num0 = 16'd3;
    step(); req0 = 1;
    for (int i = 0; i < 50 && g_own.size() <= gs; i++) @(negedge clk);
    step(); req0 = 0;
    repeat (5) @(negedge clk);
    checks++; if (arb_busy !== 1'b1) begin errors++; $display("FAIL burst_arb_busy: got %b expected 1", arb_busy); end
    for (int i = 0; i < 500 && d_own.size() <= ds; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    checks++; if (st_addr.size() - s !== 3) begin errors++; $display("FAIL burst_nstart: got %0d expected 3", st_addr.size() - s); end
    checks++; if ({at_a(s), at_a(s + 1), at_a(s + 2)} !== {32'd16448, 32'd16449, 32'd16450}) begin errors++; $display("FAIL burst_addrs: got %0d %0d %0d expected 16448 16449 16450", at_a(s), at_a(s + 1), at_a(s + 2)); end
    checks++; if (g_own.size() - gs !== 1 || at(g_own, gs) !== 0) begin errors++; $display("FAIL burst_ack: got %0d acks owner %0d expected 1 ack owner 0", g_own.size() - gs, at(g_own, gs)); end
    checks++; if (d_own.size() - ds !== 1 || at(d_own, ds) !== 0) begin errors++; $display("FAIL burst_done: got %0d dones owner %0d expected 1 done owner 0", d_own.size() - ds, at(d_own, ds)); end
    checks++; if (at(st_cyc, s) !== at(g_cyc, gs) + 1) begin errors++; $display("FAIL burst_start_latency: got %0d expected %0d", at(st_cyc, s), at(g_cyc, gs) + 1); end
    checks++; if (at(st_cyc, s + 1) !== at(f_cyc, fs) + 2) begin errors++; $display("FAIL burst_next_start: got %0d expected %0d", at(st_cyc, s + 1), at(f_cyc, fs) + 2); end
    checks++; if (at(d_cyc, ds) !== at(f_cyc, fs + 2) + 2) begin errors++; $display("FAIL burst_done_cycle: got %0d expected %0d", at(d_cyc, ds), at(f_cyc, fs + 2) + 2); end
    checks++; if (arb_busy !== 1'b0) begin errors++; $display("FAIL burst_arb_idle: got %b expected 0", arb_busy); end
  endtask

  task automatic test_zero_count();
    int s, gs, ds;
    s = st_addr.size(); gs = g_own.size(); ds = d_own.size();
    addr1 = 32'h0000_0700; num1 = 16'd0;
    step(); req1 = 1;
    for (int i = 0; i < 50 && g_own.size() <= gs; i++) @(negedge clk);
    step(); req1 = 0;
    repeat (30) @(negedge clk);
    checks++; if (at(g_own, gs) !== 1 || at(d_own, ds) !== 1) begin errors++; $display("FAIL zero_owner: got ack %0d done %0d expected 1 1", at(g_own, gs), at(d_own, ds)); end
    checks++; if (at(d_cyc, ds) !== at(g_cyc, gs) + 1) begin errors++; $display("FAIL zero_done_cycle: got %0d expected %0d", at(d_cyc, ds), at(g_cyc, gs) + 1); end
    checks++; if (st_addr.size() !== s) begin errors++; $display("FAIL zero_no_start: got %0d starts expected 0", st_addr.size() - s); end
  endtask

  task automatic test_wrap();
    int s, ds;
    s = st_addr.size(); ds = d_own.size();
    busy_len = 3; addr0 = 32'hFFFF_FFFF; num0 = 16'd2;
    step(); req0 = 1;
    for (int i = 0; i < 50 && st_addr.size() <= s; i++) @(negedge clk);
    step(); req0 = 0;
    for (int i = 0; i < 100 && d_own.size() <= ds; i++) @(negedge clk);
    checks++; if ({at_a(s), at_a(s + 1)} !== {32'hFFFF_FFFF, 32'h0}) begin errors++; $display("FAIL wrap_addrs: got %0h %0h expected ffffffff 0", at_a(s), at_a(s + 1)); end
  endtask

  task automatic test_data_route();
    int s, ds, v0, v1, bad;
    s = st_addr.size(); ds = d_own.size(); v0 = n_ve0; v1 = n_ve1; bad = 0;
    busy_len = 300; addr1 = 32'h100; num1 = 16'd1;
    step(); req1 = 1;
    for (int i = 0; i < 50 && st_addr.size() <= s; i++) @(negedge clk);
    req1 = 0;
    for (int i = 0; i < 256; i++) begin
      step(); sd_rd_val_en = 1; sd_rd_val_data = w(i);
      @(negedge clk);
      if (i > 0 && (val_en1 !== 1'b1 || val_en0 !== 1'b0 || val_data !== w(i - 1))) bad++;
    end
    step(); sd_rd_val_en = 0;
    @(negedge clk);
    if (val_en1 !== 1'b1 || val_data !== w(255)) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL data_inline: got %0d bad words expected 0", bad); end
    for (int i = 0; i < 400 && d_own.size() <= ds; i++) @(negedge clk);
    checks++; if (at(d_own, ds) !== 1) begin errors++; $display("FAIL data_done_owner: got %0d expected 1", at(d_own, ds)); end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin step(); sd_rd_val_en = 1; sd_rd_val_data = 16'hBAD0 + 16'(i); end
    step(); sd_rd_val_en = 0;
    repeat (3) @(negedge clk);
    checks++; if (n_ve1 - v1 !== 256) begin errors++; $display("FAIL data_count1: got %0d expected 256", n_ve1 - v1); end
    checks++; if (n_ve0 - v0 !== 0) begin errors++; $display("FAIL data_count0: got %0d expected 0", n_ve0 - v0); end
  endtask

  task automatic test_reset_mid();
    int s, ds;
    s = st_addr.size(); ds = d_own.size();
    busy_len = 20; addr0 = 32'h1000; num0 = 16'd5;
    step(); req0 = 1;
    for (int i = 0; i < 50 && st_addr.size() <= s; i++) @(negedge clk);
    req0 = 0;
    for (int i = 0; i < 100 && st_addr.size() < s + 2; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    @(posedge clk); #3 rst_n = 0; #1;
    checks++; if ({ack0, ack1, done0, done1, err, arb_busy, rd_start_en, val_en0, val_en1, owner} !== 10'b1 || rd_sec_addr !== 32'd0) begin errors++; $display("FAIL midreset_outputs: got %b addr %0h expected 0000000001 addr 0", {ack0, ack1, done0, done1, err, arb_busy, rd_start_en, val_en0, val_en1, owner}, rd_sec_addr); end
    repeat (2) step();
    rst_n = 1;
    repeat (40) @(negedge clk);
    checks++; if (d_own.size() !== ds) begin errors++; $display("FAIL midreset_no_done: got %0d dones expected 0", d_own.size() - ds); end
    s = st_addr.size(); addr0 = 32'h2000; num0 = 16'd2;
    step(); req0 = 1;
    for (int i = 0; i < 50 && st_addr.size() <= s; i++) @(negedge clk);
    req0 = 0;
    for (int i = 0; i < 200 && d_own.size() <= ds; i++) @(negedge clk);
    checks++; if ({at_a(s), at_a(s + 1)} !== {32'h2000, 32'h2001}) begin errors++; $display("FAIL midreset_restart: got %0h %0h expected 2000 2001", at_a(s), at_a(s + 1)); end
    checks++; if (at(d_own, ds) !== 0) begin errors++; $display("FAIL midreset_done: got %0d expected 0", at(d_own, ds)); end
  endtask

`ifdef SD_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int s, ds, es;
    s = st_addr.size(); ds = d_own.size(); es = e_cyc.size();
    hold_busy = 1; addr0 = 32'h55; num0 = 16'd1;
    step(); req0 = 1;
    for (int i = 0; i < 50 && st_addr.size() <= s; i++) @(negedge clk);
    req0 = 0;
    for (int i = 0; i < 300 && e_cyc.size() <= es; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    checks++; if (at(e_cyc, es) !== at(st_cyc, s) + 100) begin errors++; $display("FAIL timeout_cycle: got %0d expected %0d", at(e_cyc, es), at(st_cyc, s) + 100); end
    checks++; if (d_own.size() !== ds) begin errors++; $display("FAIL timeout_no_done: got %0d dones expected 0", d_own.size() - ds); end
    checks++; if (arb_busy !== 1'b0) begin errors++; $display("FAIL timeout_arb_busy: got %b expected 0", arb_busy); end
    hold_busy = 0;
    repeat (30) @(negedge clk);
  endtask
`else
  task automatic test_timeout();
    checks++; if (e_cyc.size() !== 0) begin errors++; $display("FAIL no_timeout_err: got %0d err pulses expected 0", e_cyc.size()); end
  endtask
`endif

  initial begin
    req0 = 1; req1 = 1; num0 = 16'd1; num1 = 16'd1; addr0 = 32'h10; addr1 = 32'h20;
    test_reset();
    test_round_robin();
    test_burst3();
    test_zero_count();
    test_wrap();
    test_data_route();
    test_reset_mid();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
